pipeline_hazard_ctrl: RTL and testbench

//   Central sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for a 5-stage MIPS pipeline
//   (IF/ID/EX/MEM/WB). It drives the forwarding selects, load-use stalls,
//   branch/jump flushes and the PC-source select. It also runs the syscall
//   drain/halt state machine. The datapath latches follow its outputs.
//
//   Optional feature macro: HAZARD_PERF_EN
//     defined     : stall_cnt / flush_cnt are saturating perf counters
//     not defined : both counters are tied to zero and have no flops
//
// Ports
//   clk, reset                      rising-edge clock, sync active-high reset
//   ifid_rs/rt, ifid_use_rs/rt      source operands of the instruction in ID
//   id_jump, id_syscall             J/JAL or SYSCALL decoded in ID
//   idex_rs/rt/rd, idex_is_load     operands/destination of the instr in EX
//   ex_branch_tkn                   BNE/JR resolved taken in EX
//   exmem_rd/we, memwb_rd/we        writeback targets of the older instrs
//   resume                          leave HALTED
//   fwd_a, fwd_b                    00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_if, stall_id              hold PC / hold IF/ID
//   flush_ifid, flush_idex          load a NOP into IF/ID / ID/EX
//   pc_sel                          00 PC+1, 01 jump target, 10 branch/JR target
//   halted                          registered; pipeline stopped
//   stall_cnt, flush_cnt            load-use stall cycles / redirect events
//
// State table
//   RUN    | normal issue; hazards resolved combinationally
//   DRAIN  | syscall seen; fetch held while older instructions retire
//   HALTED | pipeline stopped until resume
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_use_rs,
  input  logic              ifid_use_rt,
  input  logic              id_jump,
  input  logic              id_syscall,
  input  logic [REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_is_load,
  input  logic              ex_branch_tkn,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_we,
  input  logic              resume,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [1:0]        pc_sel,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // drain_cnt needs at least one bit even when DRAIN_CYCLES == 1
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_DRAIN  = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   drain_cnt, drain_cnt_nxt;
  logic            halted_nxt;
  logic            load_use;

  // ---------------------------------------------------------------------
  // Forwarding: active in every state. EX/MEM holds the younger result so
  // it wins over MEM/WB; $0 is hardwired and never forwarded.
  // ---------------------------------------------------------------------
  always_comb begin
    fwd_a = FWD_RF;
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == idex_rs))
      fwd_a = FWD_EXMEM;
    else if (memwb_we && (memwb_rd != '0) && (memwb_rd == idex_rs))
      fwd_a = FWD_MEMWB;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == idex_rt))
      fwd_b = FWD_EXMEM;
    else if (memwb_we && (memwb_rd != '0) && (memwb_rd == idex_rt))
      fwd_b = FWD_MEMWB;
  end

  // A load in EX whose destination is read by the instruction in ID. Once
  // the bubble is inserted the load moves to MEM and this drops by itself.
  assign load_use = idex_is_load && (idex_rd != '0) &&
                    ((ifid_use_rs && (idex_rd == ifid_rs)) ||
                     (ifid_use_rt && (idex_rd == ifid_rt)));

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      halted    <= halted_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and pipeline controls
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    halted_nxt    = halted;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    pc_sel        = PC_SEQ;

    case (state)
      S_RUN: begin
        halted_nxt = 1'b0;
        if (ex_branch_tkn) begin
          // Taken branch squashes everything younger, including a
          // syscall sitting in ID.
          pc_sel     = PC_BRANCH;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (load_use) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          flush_idex = 1'b1;
        end else if (id_jump) begin
          pc_sel     = PC_JUMP;
          flush_ifid = 1'b1;
        end else if (id_syscall) begin
          // Hold fetch from the decode cycle onward so nothing younger
          // than the syscall enters the pipe.
          stall_if      = 1'b1;
          flush_ifid    = 1'b1;
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = DRAIN_LAST;
        end
      end

      S_DRAIN: begin
        if (ex_branch_tkn) begin
          // An older branch resolved taken: the syscall was on the wrong
          // path, so abandon the drain and redirect.
          pc_sel        = PC_BRANCH;
          flush_ifid    = 1'b1;
          flush_idex    = 1'b1;
          state_nxt     = S_RUN;
          drain_cnt_nxt = '0;
          halted_nxt    = 1'b0;
        end else begin
          stall_if   = 1'b1;
          flush_ifid = 1'b1;
          if (drain_cnt == '0) begin
            state_nxt  = S_HALTED;
            halted_nxt = 1'b1;
          end else begin
            drain_cnt_nxt = drain_cnt - DW'(1);
          end
        end
      end

      S_HALTED: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        if (resume) begin
          state_nxt  = S_RUN;
          halted_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt     = S_RUN;
        drain_cnt_nxt = '0;
        halted_nxt    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic stall_evt;
  logic flush_evt;

  // A load-use bubble only counts when no taken branch overrides it.
  assign stall_evt = (state == S_RUN) && load_use && !ex_branch_tkn;
  // Every branch or jump redirect shows up as a non-sequential pc_sel.
  assign flush_evt = (pc_sel != PC_SEQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Expected outputs for each step
// are pushed to a scoreboard queue when the inputs are driven and popped
// when the DUT outputs are sampled.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW       = 5;
  localparam int DRAIN_CYCLES = 4;
  localparam int CNT_W        = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic              ifid_use_rs, ifid_use_rt, id_jump, id_syscall, idex_is_load;
  logic              ex_branch_tkn, exmem_we, memwb_we, resume;
  logic [1:0]        fwd_a, fwd_b, pc_sel;
  logic              stall_if, stall_id, flush_ifid, flush_idex, halted;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .id_jump(id_jump), .id_syscall(id_syscall),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_is_load(idex_is_load), .ex_branch_tkn(ex_branch_tkn),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we),
    .memwb_rd(memwb_rd), .memwb_we(memwb_we),
    .resume(resume),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_if(stall_if), .stall_id(stall_id),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .pc_sel(pc_sel), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] fa, fb, pc;
    logic       si, sd, fi, fx, h;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Push the expected control outputs for the current input set.
  task automatic exp_out(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                         input logic si, input logic sd, input logic fi, input logic fx,
                         input logic [1:0] pc, input logic h);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.si = si; e.sd = sd;
    e.fi = fi; e.fx = fx; e.pc = pc; e.h = h;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then pop and compare.
  task automatic check_out();
    exp_t e;
    #2;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".fwd_a"},      32'(fwd_a),      32'(e.fa));
    chk({e.tag, ".fwd_b"},      32'(fwd_b),      32'(e.fb));
    chk({e.tag, ".stall_if"},   32'(stall_if),   32'(e.si));
    chk({e.tag, ".stall_id"},   32'(stall_id),   32'(e.sd));
    chk({e.tag, ".flush_ifid"}, 32'(flush_ifid), 32'(e.fi));
    chk({e.tag, ".flush_idex"}, 32'(flush_idex), 32'(e.fx));
    chk({e.tag, ".pc_sel"},     32'(pc_sel),     32'(e.pc));
    chk({e.tag, ".halted"},     32'(halted),     32'(e.h));
  endtask

  task automatic check_cnt(input string tag);
    int es, ef;
`ifdef HAZARD_PERF_EN
    es = exp_stall; ef = exp_flush;
`else
    es = 0; ef = 0;
`endif
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(es));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(ef));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifid_rs = '0; ifid_rt = '0; ifid_use_rs = 0; ifid_use_rt = 0;
    id_jump = 0; id_syscall = 0;
    idex_rs = '0; idex_rt = '0; idex_rd = '0; idex_is_load = 0;
    ex_branch_tkn = 0;
    exmem_rd = '0; exmem_we = 0; memwb_rd = '0; memwb_we = 0;
    resume = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;

    // Reset state
    exp_out("reset", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    check_out();
    check_cnt("reset");
    tick();

    // Forwarding: EX/MEM wins over MEM/WB for the same register
    exmem_we = 1; exmem_rd = 9; memwb_we = 1; memwb_rd = 9; idex_rs = 9; idex_rt = 0;
    exp_out("fwd_exmem_prio", 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    check_out(); tick();

    exmem_we = 0; idex_rt = 9;
    exp_out("fwd_memwb", 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 0);
    check_out(); tick();

    exmem_we = 1; exmem_rd = 7; idex_rt = 7;
    exp_out("fwd_mixed", 2'b10, 2'b01, 0, 0, 0, 0, 2'b00, 0);
    check_out(); tick();

    // $0 is never forwarded
    exmem_rd = 0; memwb_rd = 0; idex_rs = 0; idex_rt = 0;
    exp_out("fwd_zero", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    check_out(); tick();
    idle_inputs();

    // Load-use on rt
    idex_is_load = 1; idex_rd = 10; ifid_rt = 10; ifid_use_rt = 1;
    exp_out("load_use", 2'b00, 2'b00, 1, 1, 0, 1, 2'b00, 0);
    check_out(); tick(); exp_stall++;
    idle_inputs();
    exp_out("load_use_clear", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    check_out();
    check_cnt("after_load_use");
    tick();

    // No stall: rt match but rt not read; load to $0
    idex_is_load = 1; idex_rd = 10; ifid_rt = 10; ifid_use_rt = 0; ifid_rs = 3; ifid_use_rs = 1;
    exp_out("load_no_use", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    check_out(); tick();
    idex_rd = 0; ifid_rs = 0;
    exp_out("load_rd0", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    check_out(); tick();
    idle_inputs();

    // Jump
    id_jump = 1;
    exp_out("jump", 2'b00, 2'b00, 0, 0, 1, 0, 2'b01, 0);
    check_out(); tick(); exp_flush++;
    idle_inputs();

    // Branch beats load-use and jump
    ex_branch_tkn = 1; id_jump = 1;
    idex_is_load = 1; idex_rd = 10; ifid_rs = 10; ifid_use_rs = 1;
    exp_out("branch_prio", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 0);
    check_out(); tick(); exp_flush++;
    idle_inputs();
    check_cnt("after_branch");

    // Syscall squashed by a taken branch
    ex_branch_tkn = 1; id_syscall = 1;
    exp_out("sys_squashed", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 0);
    check_out(); tick(); exp_flush++;
    idle_inputs();
    exp_out("sys_squashed_run", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    check_out(); tick();

    // Syscall drain to HALTED, then resume
    id_syscall = 1;
    exp_out("sys_decode", 2'b00, 2'b00, 1, 0, 1, 0, 2'b00, 0);
    check_out(); tick();
    idle_inputs();
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      exp_out($sformatf("drain_%0d", i), 2'b00, 2'b00, 1, 0, 1, 0, 2'b00, 0);
      check_out(); tick();
    end
    exmem_we = 1; exmem_rd = 4; idex_rs = 4;
    exp_out("halted", 2'b01, 2'b00, 1, 1, 0, 0, 2'b00, 1);
    check_out(); tick();
    idle_inputs();
    exp_out("halted_hold", 2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 1);
    check_out(); tick();
    resume = 1;
    exp_out("resume_edge", 2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 1);
    check_out(); tick();
    resume = 0;
    exp_out("resumed", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    check_out(); tick();

    // Branch during DRAIN aborts back to RUN
    id_syscall = 1;
    exp_out("sys2_decode", 2'b00, 2'b00, 1, 0, 1, 0, 2'b00, 0);
    check_out(); tick();
    idle_inputs();
    exp_out("sys2_drain", 2'b00, 2'b00, 1, 0, 1, 0, 2'b00, 0);
    check_out(); tick();
    ex_branch_tkn = 1;
    exp_out("drain_abort", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 0);
    check_out(); tick(); exp_flush++;
    idle_inputs();
    for (int i = 0; i < DRAIN_CYCLES + 1; i++) begin
      exp_out($sformatf("after_abort_%0d", i), 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
      check_out(); tick();
    end
    check_cnt("before_reset");

    // Reset while HALTED
    id_syscall = 1;
    tick();
    idle_inputs();
    repeat (DRAIN_CYCLES) tick();
    exp_out("halted2", 2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 1);
    check_out();
    reset = 1;
    tick();
    reset = 0;
    exp_stall = 0; exp_flush = 0;
    exp_out("reset_from_halt", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    check_out();
    check_cnt("reset_from_halt");
    tick();
    id_jump = 1;
    exp_out("jump_after_reset", 2'b00, 2'b00, 0, 0, 1, 0, 2'b01, 0);
    check_out(); tick(); exp_flush++;
    idle_inputs();
    #2;
    check_cnt("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
